// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the fetch PC, issues imem word requests and
// buffers {pc, instr} responses in a fall-through FIFO for IF/ID.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   fetch_pc_d;
  logic [31:0]   drop_addr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic        ack;
  logic        push;
  logic        pop;
  logic [31:0] target;
  logic [31:0] head_pc;
  logic [31:0] head_instr;

  assign ack    = imem_ack_i & imem_req_o;
  assign push   = (state_q == REQ) & ack
                & ~redirect_i;
  assign pop    = valid_o & ~stall_i
                & ~redirect_i;
  assign target = {redirect_pc_i[31:2], 2'b00};

  assign imem_req_o  = (state_q != IDLE);
  assign imem_addr_o = (state_q == DROP)
                     ? drop_addr_q
                     : fetch_pc_q;

  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_instr = instr_mem[rd_ptr_q];

  assign valid_o    = (count_q != '0);
  assign pc_o       = valid_o ? head_pc : '0;
  assign instr_o    = valid_o ? head_instr : '0;
  assign pc_plus4_o = valid_o
                    ? head_pc + 32'd4
                    : '0;

  // Occupancy after this cycle's push/pop; a redirect empties the queue.
  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      redirect_i:    count_d = '0;
      push && !pop:  count_d = count_q + CW'(1);
      !push && pop:  count_d = count_q - CW'(1);
      default:       count_d = count_q;
    endcase
  end

  // Request FSM and fetch PC; a redirect outranks the normal sequencing.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      fetch_pc_d = target;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = ack ? REQ : DROP;
        DROP:    state_d = ack ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_q < FULL)
            state_d = REQ;
        end
        REQ: begin
          if (ack) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d = (count_d < FULL)
                    ? REQ : IDLE;
          end
        end
        DROP: begin
          if (ack)
            state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state; the in-flight address is frozen when a request is orphaned.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (redirect_i && state_q == REQ && !ack)
        drop_addr_q <= fetch_pc_q;
      if (redirect_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)
          wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)
          rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Queue storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= imem_data_i;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a latency-programmable
// memory responder and an expected-PC scoreboard.
module tb_instr_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q [$];
  logic [31:0] sb_e;

  int lat       = 0;
  bit force_ack = 1'b0;
  int cnt       = 0;
  bit ack_q     = 1'b0;
  bit seen      = 1'b0;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i),
    .valid_o(valid_o),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .pc_plus4_o(pc_plus4_o)
  );

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(
    input bit st,
    input int l
  );
    rst_n      = 1'b0;
    redirect_i = 1'b0;
    stall_i    = st;
    lat        = l;
    force_ack  = 1'b0;
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // Memory: ack after lat wait cycles per request, or forced ack.
  always @(negedge clk_i) begin
    if (ack_q) cnt = 0;
    if (force_ack) begin
      imem_ack_i  = 1'b1;
      imem_data_i = 32'hBAD0_BAD0;
    end else if (imem_req_o) begin
      if (cnt >= lat) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(imem_addr_o);
      end else begin
        imem_ack_i = 1'b0;
        cnt++;
      end
    end else begin
      imem_ack_i = 1'b0;
      cnt = 0;
    end
    ack_q = imem_ack_i;
  end

  // Scoreboard: every accepted instruction is checked against the queue.
  always @(negedge clk_i) begin
    if (rst_n && valid_o && !stall_i
        && !redirect_i && exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      chk("sb_pc", pc_o, sb_e);
      chk("sb_instr", instr_o, mem_word(sb_e));
      chk("sb_pc4", pc_plus4_o, sb_e + 32'd4);
    end
  end

  initial begin
    rst_n         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    stall_i       = 1'b0;
    #2;
    step();
    step();
    chk("rst_valid", valid_o, 0);
    chk("rst_req", imem_req_o, 0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_pc4", pc_plus4_o, 0);

    // 1: zero-wait streaming
    lat = 0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    rst_n = 1'b1;
    chk("t1_req_c1", imem_req_o, 0);
    step();
    chk("t1_req_c2", imem_req_o, 1);
    chk("t1_addr_c2", imem_addr_o, 32'h0);
    chk("t1_valid_c2", valid_o, 0);
    step();
    chk("t1_valid0", valid_o, 1);
    chk("t1_pc0", pc_o, 32'h0);
    chk("t1_pc4_0", pc_plus4_o, 32'h4);
    step();
    chk("t1_pc1", pc_o, 32'h4);
    step();
    chk("t1_pc2", pc_o, 32'h8);
    step();
    chk("t1_valid3", valid_o, 1);
    chk("t1_pc3", pc_o, 32'hC);
    wait_drain("t1_drain");

    // 2: stall fills queue, then drain and resume
    do_reset(1'b1, 0);
    repeat (8) step();
    chk("t2_req_full", imem_req_o, 0);
    chk("t2_valid", valid_o, 1);
    chk("t2_pc_hold", pc_o, 32'h0);
    chk("t2_instr", instr_o, mem_word(32'h0));
    for (int i = 0; i < 6; i++)
      exp_q.push_back(32'(i * 4));
    stall_i = 1'b0;
    step();
    chk("t2_pc4", pc_o, 32'h4);
    chk("t2_req_idle", imem_req_o, 0);
    step();
    chk("t2_pc8", pc_o, 32'h8);
    chk("t2_req_resume", imem_req_o, 1);
    chk("t2_addr_resume", imem_addr_o, 32'h10);
    step();
    chk("t2_pcC", pc_o, 32'hC);
    step();
    chk("t2_pc10", pc_o, 32'h10);
    wait_drain("t2_drain");

    // 3: redirect while a slow fetch is outstanding
    do_reset(1'b0, 3);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int i = 0; i < 40; i++) begin
      step();
      if (imem_req_o && imem_addr_o == 32'h8)
        break;
    end
    chk("t3_req8", imem_addr_o, 32'h8);
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    exp_q.delete();
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h48);
    step();
    redirect_i = 1'b0;
    chk("t3_hold_addr", imem_addr_o, 32'h8);
    chk("t3_hold_req", imem_req_o, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_addr_o != 32'h8) break;
      if (valid_o) seen = 1'b1;
      step();
    end
    chk("t3_no_stale", seen, 0);
    chk("t3_new_addr", imem_addr_o, 32'h40);
    wait_drain("t3_drain");

    // 4: redirect coinciding with ack and pop
    do_reset(1'b1, 0);
    repeat (3) step();
    chk("t4_valid", valid_o, 1);
    chk("t4_pc", pc_o, 32'h0);
    chk("t4_req", imem_req_o, 1);
    stall_i       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h80;
    exp_q.delete();
    exp_q.push_back(32'h80);
    exp_q.push_back(32'h84);
    exp_q.push_back(32'h88);
    step();
    redirect_i = 1'b0;
    chk("t4_flush", valid_o, 0);
    chk("t4_req_tgt", imem_req_o, 1);
    chk("t4_addr_tgt", imem_addr_o, 32'h80);
    step();
    chk("t4_valid_tgt", valid_o, 1);
    chk("t4_pc_tgt", pc_o, 32'h80);
    wait_drain("t4_drain");

    // 5: reset mid-transfer, late ack ignored
    do_reset(1'b0, 3);
    step();
    step();
    chk("t5_req_wait", imem_req_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_req", imem_req_o, 0);
    chk("t5_async_valid", valid_o, 0);
    chk("t5_async_addr", imem_addr_o, 32'h0);
    step();
    step();
    lat       = 0;
    force_ack = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    rst_n = 1'b1;
    step();
    force_ack = 1'b0;
    chk("t5_ign_valid", valid_o, 0);
    chk("t5_restart_req", imem_req_o, 1);
    chk("t5_restart_addr", imem_addr_o, 32'h0);
    step();
    chk("t5_valid", valid_o, 1);
    chk("t5_pc", pc_o, 32'h0);
    chk("t5_instr", instr_o, mem_word(32'h0));
    wait_drain("t5_drain");

    // 6: wrap at top of address space, unaligned target
    do_reset(1'b0, 0);
    repeat (5) step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    step();
    redirect_i = 1'b0;
    chk("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    chk("t6_flush", valid_o, 0);
    step();
    chk("t6_pc_top", pc_o, 32'hFFFF_FFFC);
    chk("t6_pc4_wrap", pc_plus4_o, 32'h0);
    chk("t6_addr_wrap", imem_addr_o, 32'h0);
    step();
    chk("t6_pc_wrap", pc_o, 32'h0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h43;
    exp_q.delete();
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    step();
    redirect_i = 1'b0;
    chk("t6_addr_align", imem_addr_o, 32'h40);
    step();
    chk("t6_valid_align", valid_o, 1);
    chk("t6_pc_align", pc_o, 32'h40);
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
